// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller. Each cycle it decides whether the F, D and E
// pipeline registers advance, hold or are flushed, and whether a bubble is
// pushed into the M registers. It handles load-use hazards, taken-branch
// flushes and multi-cycle mul/div occupancy of EX. It also keeps a saturating
// stall counter and a sticky mul/div timeout flag for debug.
//
// All state is updated on the falling edge of clk, the same edge the
// pipeline registers use. The control outputs are decoded combinationally
// from the state and the current inputs, so a decision takes zero cycles.
//
// Parameters:
//   MD_MAX_CYCLES  longest stay in MD_BUSY before a forced release (>= 2)
//   STALL_CNT_W    width of the stall counter
//
// Ports:
//   clk                 clock; state changes on the falling edge
//   reset               asynchronous, active-high reset
//   rs1D, rs2D          source registers of the Decode instruction
//   usesRs1D, usesRs2D  Decode instruction really reads rs1 / rs2
//   rdE                 destination register of the Execute instruction
//   memReadE            Execute instruction is a load
//   branchTakenE        taken branch/jump resolved in EX this cycle
//   mdStartE            EX holds a multi-cycle mul/div op
//   mdDone              mul/div result valid this cycle
//   stallF/D/E          hold the F, D, E pipeline registers
//   flushD/E            load a NOP into the D, E pipeline registers
//   bubbleM             load a NOP into the M pipeline registers
//   stateOut            current state (00 RUN, 01 MD_BUSY)
//   stallCount          saturating count of cycles with stallF=1
//   mdTimeout           sticky: a mul/div ran past MD_MAX_CYCLES
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MD_MAX_CYCLES = 34,
    parameter int STALL_CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             rs1D,
    input  logic [4:0]             rs2D,
    input  logic                   usesRs1D,
    input  logic                   usesRs2D,
    input  logic [4:0]             rdE,
    input  logic                   memReadE,
    input  logic                   branchTakenE,
    input  logic                   mdStartE,
    input  logic                   mdDone,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   stallE,
    output logic                   flushD,
    output logic                   flushE,
    output logic                   bubbleM,
    output logic [1:0]             stateOut,
    output logic [STALL_CNT_W-1:0] stallCount,
    output logic                   mdTimeout
);

    localparam int MD_CNT_W = (MD_MAX_CYCLES > 1) ? $clog2(MD_MAX_CYCLES) : 1;
    localparam logic [MD_CNT_W-1:0]    MD_LAST   = MD_CNT_W'(MD_MAX_CYCLES - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MD_BUSY = 2'b01
    } state_e;

    state_e                 state_q,       state_d;
    logic [MD_CNT_W-1:0]    md_cnt_q,      md_cnt_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
    logic                   md_timeout_q,  md_timeout_d;

    logic load_use;

    // rdE of x0 never creates a dependency: x0 is hard-wired to zero.
    assign load_use = memReadE && (rdE != 5'd0) &&
                      ((usesRs1D && (rs1D == rdE)) || (usesRs2D && (rs2D == rdE)));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case/if tree can leave one unassigned and infer a latch.
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;
        md_timeout_d  = md_timeout_q;
        stallF        = 1'b0;
        stallD        = 1'b0;
        stallE        = 1'b0;
        flushD        = 1'b0;
        flushE        = 1'b0;
        bubbleM       = 1'b0;

        // Outputs stay quiet for the whole reset pulse, whatever the inputs.
        if (!reset) begin
            case (state_q)
                ST_MD_BUSY: begin
                    // EX is owned by the mul/div: branch and load-use are
                    // irrelevant until it finishes.
                    if (!mdDone) begin
                        stallF  = 1'b1;
                        stallD  = 1'b1;
                        stallE  = 1'b1;
                        bubbleM = 1'b1;
                        if (md_cnt_q == MD_LAST) begin
                            state_d      = ST_RUN;
                            md_timeout_d = 1'b1;
                            md_cnt_d     = '0;
                        end else begin
                            md_cnt_d = md_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d  = ST_RUN;
                        md_cnt_d = '0;
                    end
                end

                // RUN, plus the unused encodings, which behave like RUN for
                // one cycle and then fall back to RUN.
                default: begin
                    state_d  = ST_RUN;
                    md_cnt_d = '0;
                    if (branchTakenE) begin
                        // D holds a wrong-path instruction, so a flush beats
                        // any stall it might have caused.
                        flushD = 1'b1;
                        flushE = 1'b1;
                    end else if (mdStartE && !mdDone) begin
                        stallF  = 1'b1;
                        stallD  = 1'b1;
                        stallE  = 1'b1;
                        bubbleM = 1'b1;
                        if (state_q == ST_RUN) begin
                            state_d = ST_MD_BUSY;
                        end
                    end else if (load_use) begin
                        // Hold F/D one cycle and turn the E slot into a bubble.
                        stallF = 1'b1;
                        stallD = 1'b1;
                        flushE = 1'b1;
                    end
                end
            endcase
        end

        stall_count_d = stall_count_q;
        if (stallF && (stall_count_q != STALL_MAX)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // NOTE: state moves on the falling edge to line up with the pipeline
    // registers; non-blocking assignments keep every flop sampling the
    // pre-edge values.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            md_cnt_q      <= '0;
            stall_count_q <= '0;
            md_timeout_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
            md_timeout_q  <= md_timeout_d;
        end
    end

    assign stateOut   = state_q;
    assign stallCount = stall_count_q;
    assign mdTimeout  = md_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl. Two instances share all inputs: dut_a uses
// MD_MAX_CYCLES=4 and STALL_CNT_W=3 so timeout and saturation are reachable
// in a few cycles; dut_b uses the default parameters. Inputs are driven just
// after the falling edge and outputs are sampled on the rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] rs1_d, rs2_d, rd_e;
    logic use1_d, use2_d, mem_read_e, branch_e, md_start_e, md_done;

    logic stall_f_a, stall_d_a, stall_e_a, flush_d_a, flush_e_a, bubble_m_a, timeout_a;
    logic [1:0] state_a;
    logic [2:0] count_a;
    logic stall_f_b, stall_d_b, stall_e_b, flush_d_b, flush_e_b, bubble_m_b, timeout_b;
    logic [1:0] state_b;
    logic [31:0] count_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_MAX_CYCLES(4), .STALL_CNT_W(3)) dut_a (
        .clk(clk), .reset(reset),
        .rs1D(rs1_d), .rs2D(rs2_d), .usesRs1D(use1_d), .usesRs2D(use2_d),
        .rdE(rd_e), .memReadE(mem_read_e), .branchTakenE(branch_e),
        .mdStartE(md_start_e), .mdDone(md_done),
        .stallF(stall_f_a), .stallD(stall_d_a), .stallE(stall_e_a),
        .flushD(flush_d_a), .flushE(flush_e_a), .bubbleM(bubble_m_a),
        .stateOut(state_a), .stallCount(count_a), .mdTimeout(timeout_a)
    );

    hazard_ctrl dut_b (
        .clk(clk), .reset(reset),
        .rs1D(rs1_d), .rs2D(rs2_d), .usesRs1D(use1_d), .usesRs2D(use2_d),
        .rdE(rd_e), .memReadE(mem_read_e), .branchTakenE(branch_e),
        .mdStartE(md_start_e), .mdDone(md_done),
        .stallF(stall_f_b), .stallD(stall_d_b), .stallE(stall_e_b),
        .flushD(flush_d_b), .flushE(flush_e_b), .bubbleM(bubble_m_b),
        .stateOut(state_b), .stallCount(count_b), .mdTimeout(timeout_b)
    );

    // Control bundle order: {stallF, stallD, stallE, flushD, flushE, bubbleM}
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       mem_rd;
        logic       br;
        logic       md_start;
        logic       md_done;
        logic [5:0] exp_ctl;
        logic [1:0] exp_state;
    } vec_t;

    function automatic logic [5:0] ctl_a();
        return {stall_f_a, stall_d_a, stall_e_a, flush_d_a, flush_e_a, bubble_m_a};
    endfunction

    function automatic logic [5:0] ctl_b();
        return {stall_f_b, stall_d_b, stall_e_b, flush_d_b, flush_e_b, bubble_m_b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_d = '0; rs2_d = '0; rd_e = '0;
        use1_d = 0; use2_d = 0; mem_read_e = 0;
        branch_e = 0; md_start_e = 0; md_done = 0;
    endtask

    task automatic apply(input vec_t v);
        rs1_d = v.rs1; rs2_d = v.rs2; use1_d = v.use1; use2_d = v.use2;
        rd_e = v.rd; mem_read_e = v.mem_rd; branch_e = v.br;
        md_start_e = v.md_start; md_done = v.md_done;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        #1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic drive_load_use();
        clear_inputs();
        mem_read_e = 1; rd_e = 5'd5; rs2_d = 5'd5; use2_d = 1;
    endtask

    vec_t vecs [13];

    initial begin
        //            rs1    rs2  u1 u2  rd    mr br ms md  ctl        state
        vecs[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 6'b000000, 2'b00}; // idle
        vecs[1]  = '{5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, 6'b110010, 2'b00}; // load-use rs2
        vecs[2]  = '{5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, 6'b110010, 2'b00}; // load-use rs1
        vecs[3]  = '{5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 6'b000000, 2'b00}; // rd = x0
        vecs[4]  = '{5'd0, 5'd5, 0, 0, 5'd5, 1, 0, 0, 0, 6'b000000, 2'b00}; // rs2 not read
        vecs[5]  = '{5'd5, 5'd5, 1, 1, 5'd5, 0, 0, 0, 0, 6'b000000, 2'b00}; // not a load
        vecs[6]  = '{5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, 6'b000110, 2'b00}; // branch beats load-use
        vecs[7]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 6'b000110, 2'b00}; // branch beats mul/div
        vecs[8]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 6'b000000, 2'b00}; // start+done same cycle
        vecs[9]  = '{5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 1, 0, 6'b111001, 2'b00}; // mul/div beats load-use
        vecs[10] = '{5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 1, 0, 6'b111001, 2'b01}; // busy ignores branch
        vecs[11] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 6'b000000, 2'b01}; // done releases EX
        vecs[12] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 6'b000000, 2'b00}; // back in RUN

        // ---- reset with mdStartE high, then release: stall in the same cycle
        clear_inputs();
        reset = 1'b1;
        md_start_e = 1;
        #1;
        check("rst_ctl", 32'(ctl_a()), 32'h0);
        check("rst_state", 32'(state_a), 32'h0);
        check("rst_count", 32'(count_a), 32'h0);
        check("rst_timeout", 32'(timeout_a), 32'h0);
        next_cycle();
        reset = 1'b0;

        // ---- mul/div: done in the fifth cycle -> 4 stalls, states 00,01,01,01,01,00
        for (int i = 0; i < 6; i++) begin
            md_done = (i == 4);
            md_start_e = (i < 5);
            @(posedge clk);
            check("md_ctl", 32'(ctl_a()), (i < 4) ? 32'h39 : 32'h0);
            check("md_state", 32'(state_a), (i == 0 || i == 5) ? 32'h0 : 32'h1);
            next_cycle();
        end
        check("md_count", 32'(count_a), 32'd4);

        // ---- table of single-cycle vectors, applied back to back
        do_reset();
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i]);
            @(posedge clk);
            check($sformatf("vec%0d_ctl_a", i), 32'(ctl_a()), 32'(vecs[i].exp_ctl));
            check($sformatf("vec%0d_ctl_b", i), 32'(ctl_b()), 32'(vecs[i].exp_ctl));
            check($sformatf("vec%0d_state", i), 32'(state_a), 32'(vecs[i].exp_state));
            next_cycle();
        end
        check("vec_count_a", 32'(count_a), 32'd4);
        check("vec_count_b", count_b, 32'd4);

        // ---- load-use costs exactly one stall; rdE=0 gives none
        do_reset();
        drive_load_use();
        @(posedge clk);
        check("lu_ctl", 32'(ctl_a()), 32'h32);
        next_cycle();
        clear_inputs();
        @(posedge clk);
        check("lu_after_ctl", 32'(ctl_a()), 32'h0);
        check("lu_count", 32'(count_a), 32'd1);
        next_cycle();
        drive_load_use();
        rd_e = 5'd0; rs2_d = 5'd0;
        @(posedge clk);
        check("lu_x0_ctl", 32'(ctl_a()), 32'h0);
        next_cycle();
        check("lu_x0_count", 32'(count_a), 32'd1);

        // ---- branch together with load-use: flush only, counter unchanged
        drive_load_use();
        branch_e = 1;
        @(posedge clk);
        check("br_lu_ctl", 32'(ctl_a()), 32'h06);
        next_cycle();
        clear_inputs();
        check("br_lu_count", 32'(count_a), 32'd1);

        // ---- reset in the middle of MD_BUSY, pending mdDone afterwards
        do_reset();
        md_start_e = 1;
        next_cycle();
        @(posedge clk);
        check("mdrst_busy", 32'(state_a), 32'h1);
        #1;
        reset = 1'b1;
        md_start_e = 0;
        md_done = 1;
        #1;
        check("mdrst_state", 32'(state_a), 32'h0);
        check("mdrst_ctl", 32'(ctl_a()), 32'h0);
        next_cycle();
        reset = 1'b0;
        @(posedge clk);
        check("mdrst_done_ctl", 32'(ctl_a()), 32'h0);
        next_cycle();
        md_done = 0;
        @(posedge clk);
        check("mdrst_done_state", 32'(state_a), 32'h0);
        next_cycle();

        // ---- timeout: dut_a releases after 1+4 stalls, dut_b keeps waiting
        do_reset();
        md_start_e = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            check($sformatf("to_stall%0d", i), 32'(stall_f_a), 32'h1);
            if (i == 4) check("to_flag_early", 32'(timeout_a), 32'h0);
            next_cycle();
        end
        md_start_e = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            if (k == 0) begin
                check("to_state_a", 32'(state_a), 32'h0);
                check("to_flag_a", 32'(timeout_a), 32'h1);
                check("to_ctl_a", 32'(ctl_a()), 32'h0);
            end
            if (k == 9) begin
                check("to_busy_b", 32'(state_b), 32'h1);
                check("to_ctl_b", 32'(ctl_b()), 32'h39);
                check("to_flag_b", 32'(timeout_b), 32'h0);
            end
            next_cycle();
        end
        md_done = 1;
        @(posedge clk);
        check("to_done_ctl_b", 32'(ctl_b()), 32'h0);
        check("to_done_state_b", 32'(state_b), 32'h1);
        next_cycle();
        md_done = 0;
        @(posedge clk);
        check("to_end_state_b", 32'(state_b), 32'h0);
        check("to_count_b", count_b, 32'd15);
        check("to_count_a", 32'(count_a), 32'd5);
        check("to_sticky_a", 32'(timeout_a), 32'h1);
        next_cycle();
        do_reset();
        check("to_cleared_a", 32'(timeout_a), 32'h0);

        // ---- saturation: 10 load-use cycles, 3-bit counter stops at 7
        drive_load_use();
        for (int i = 0; i < 10; i++) begin
            next_cycle();
        end
        clear_inputs();
        @(posedge clk);
        check("sat_count_a", 32'(count_a), 32'd7);
        check("sat_count_b", count_b, 32'd10);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
